// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the W stage and queued mul/div results.
// The pipeline wins by default; a head entry that has waited STARVE_LIMIT cycles forces a stall.
module wb_port_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int AW           = 5,
    parameter int DW           = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     RegWriteW,
    input  logic [AW-1:0]            WriteRegW,
    input  logic [DW-1:0]            ResultW,
    input  logic                     md_valid,
    input  logic [AW-1:0]            md_reg,
    input  logic [DW-1:0]            md_data,
    output logic                     md_ready,
    output logic                     StallW,
    output logic                     rf_we,
    output logic [AW-1:0]            rf_waddr,
    output logic [DW-1:0]            rf_wdata,
    output logic [$clog2(DEPTH):0]   md_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [7:0]    LIMIT_C = 8'(STARVE_LIMIT);

    logic          validQ [DEPTH];
    logic [AW-1:0] regQ   [DEPTH];
    logic [DW-1:0] dataQ  [DEPTH];
    logic [PW-1:0] rdPtr, wrPtr;
    logic [CW-1:0] count;
    logic [7:0]    age;

    logic pipeWr, notEmpty, headValid, headOk, starve;
    logic grantFifo, pop, push, squash, pushValid, notFull;

    always_comb begin
        pipeWr    = RegWriteW && (WriteRegW != '0);
        notEmpty  = (count != '0);
        notFull   = (count < DEPTH_C);
        headValid = validQ[rdPtr];
        headOk    = notEmpty && headValid;
        starve    = headOk && (age == LIMIT_C);
        grantFifo = headOk && (starve || !pipeWr);
        // Invalid heads are discarded every cycle regardless of who owns the port.
        pop       = notEmpty && (grantFifo || !headValid);
        squash    = pipeWr && !starve;
        push      = md_valid && notFull;
        // The W instruction is younger than any result arriving this cycle.
        pushValid = (md_reg != '0) && !(squash && (md_reg == WriteRegW));
    end

    always_comb begin
        md_ready = 1'b0;
        StallW   = 1'b0;
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        md_count = '0;
        if (rst_n) begin
            md_ready = notFull;
            md_count = count;
            StallW   = starve;
            if (grantFifo) begin
                rf_we    = 1'b1;
                rf_waddr = regQ[rdPtr];
                rf_wdata = dataQ[rdPtr];
            end else if (pipeWr) begin
                rf_we    = 1'b1;
                rf_waddr = WriteRegW;
                rf_wdata = ResultW;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
            age   <= '0;
            for (int i = 0; i < DEPTH; i++) validQ[i] <= 1'b0;
        end else begin
            if (squash) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (regQ[i] == WriteRegW) validQ[i] <= 1'b0;
                end
            end
            if (push) begin
                validQ[wrPtr] <= pushValid;
                wrPtr         <= wrPtr + PW'(1);
            end
            if (pop) rdPtr <= rdPtr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (pop || !headOk) age <= '0;
            else if (age != LIMIT_C) age <= age + 8'd1;
        end
    end

    // Payload needs no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            regQ[wrPtr]  <= md_reg;
            dataQ[wrPtr] <= md_data;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed checks of write-port arbitration: priority, starvation, squash, full/wrap, $0, reset.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWriteW;
    logic [4:0]  WriteRegW;
    logic [31:0] ResultW;
    logic        md_valid;
    logic [4:0]  md_reg;
    logic [31:0] md_data;
    logic        md_ready, StallW, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [2:0]  md_count;

    int tests = 0;
    int fails = 0;

    wb_port_arbiter #(.DEPTH(4), .STARVE_LIMIT(8), .AW(5), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n), .RegWriteW(RegWriteW), .WriteRegW(WriteRegW),
        .ResultW(ResultW), .md_valid(md_valid), .md_reg(md_reg), .md_data(md_data),
        .md_ready(md_ready), .StallW(StallW), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .md_count(md_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkRf(input string tag, input logic we, input logic [4:0] a,
                         input logic [31:0] d, input logic st);
        chk({tag, ".we"}, 64'(rf_we), 64'(we));
        chk({tag, ".addr"}, 64'(rf_waddr), 64'(a));
        chk({tag, ".data"}, 64'(rf_wdata), 64'(d));
        chk({tag, ".stall"}, 64'(StallW), 64'(st));
    endtask

    // Inputs change just after a falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic rw, input logic [4:0] wr, input logic [31:0] res,
                         input logic mv, input logic [4:0] mr, input logic [31:0] md);
        @(negedge clk);
        RegWriteW = rw; WriteRegW = wr; ResultW = res;
        md_valid = mv; md_reg = mr; md_data = md;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        RegWriteW = 1'b0; WriteRegW = '0; ResultW = '0;
        md_valid = 1'b0; md_reg = '0; md_data = '0;

        // reset: outputs forced low even with a W write presented
        drive(1, 5'd3, 32'h33, 1, 5'd4, 32'h44);
        drive(1, 5'd3, 32'h33, 0, 5'd0, 0);
        chkRf("rst", 0, 0, 0, 0);
        chk("rst.ready", 64'(md_ready), 0);
        chk("rst.count", 64'(md_count), 0);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        chkRf("idle", 0, 0, 0, 0);
        chk("idle.ready", 64'(md_ready), 1);
        chk("idle.count", 64'(md_count), 0);

        // 1 pipe priority
        drive(1, 5'd8, 32'h11, 1, 5'd9, 32'h22);
        chkRf("p1.c0", 1, 8, 32'h11, 0);
        chk("p1.c0.count", 64'(md_count), 0);
        drive(1, 5'd8, 32'h11, 0, 0, 0);
        chkRf("p1.c1", 1, 8, 32'h11, 0);
        chk("p1.c1.count", 64'(md_count), 1);
        drive(1, 5'd8, 32'h11, 0, 0, 0);
        chkRf("p1.c2", 1, 8, 32'h11, 0);
        drive(0, 0, 0, 0, 0, 0);
        chkRf("p1.drain", 1, 9, 32'h22, 0);
        drive(0, 0, 0, 0, 0, 0);
        chkRf("p1.empty", 0, 0, 0, 0);
        chk("p1.count", 64'(md_count), 0);

        // 2 starvation
        drive(1, 5'd8, 32'h100, 1, 5'd9, 32'h99);
        for (int k = 1; k <= 8; k++) begin
            drive(1, 5'd8, 32'h100 + 32'(k), 0, 0, 0);
            chkRf($sformatf("st.pipe%0d", k), 1, 8, 32'h100 + 32'(k), 0);
        end
        drive(1, 5'd8, 32'h333, 0, 0, 0);
        chkRf("st.force", 1, 9, 32'h99, 1);
        drive(1, 5'd8, 32'h333, 0, 0, 0);
        chkRf("st.replay", 1, 8, 32'h333, 0);
        chk("st.count", 64'(md_count), 0);

        // 3 squash: older queued result, then same-cycle push
        drive(0, 0, 0, 1, 5'd5, 32'hAA);
        chkRf("sq.push", 0, 0, 0, 0);
        drive(1, 5'd5, 32'hBB, 0, 0, 0);
        chkRf("sq.pipe", 1, 5, 32'hBB, 0);
        chk("sq.count1", 64'(md_count), 1);
        drive(0, 0, 0, 0, 0, 0);
        chkRf("sq.silent", 0, 0, 0, 0);
        chk("sq.count1b", 64'(md_count), 1);
        drive(1, 5'd6, 32'hCC, 1, 5'd6, 32'hDD);
        chkRf("sq2.pipe", 1, 6, 32'hCC, 0);
        chk("sq.count0", 64'(md_count), 0);
        drive(0, 0, 0, 0, 0, 0);
        chkRf("sq2.silent", 0, 0, 0, 0);
        chk("sq2.count1", 64'(md_count), 1);
        drive(0, 0, 0, 0, 0, 0);
        chk("sq2.count0", 64'(md_count), 0);

        // 4 full: six pushes with W busy, last two dropped
        for (int k = 1; k <= 6; k++) begin
            drive(1, 5'd20, 32'h200, 1, 5'(k), 32'h40 + 32'(k));
            chk($sformatf("full.ready%0d", k), 64'(md_ready), (k <= 4) ? 64'd1 : 64'd0);
            chkRf($sformatf("full.pipe%0d", k), 1, 20, 32'h200, 0);
        end
        // drain in order; a push while full-and-popping is refused
        for (int k = 1; k <= 4; k++) begin
            drive(0, 0, 0, (k == 1), 5'd7, 32'h77);
            chkRf($sformatf("full.drain%0d", k), 1, 5'(k), 32'h40 + 32'(k), 0);
            chk($sformatf("full.cnt%0d", k), 64'(md_count), 64'(5 - k));
        end
        drive(0, 0, 0, 0, 0, 0);
        chkRf("full.empty", 0, 0, 0, 0);
        chk("full.count", 64'(md_count), 0);

        // 4b second burst wraps pointers
        for (int k = 0; k < 4; k++) drive(1, 5'd20, 32'h201, 1, 5'd10 + 5'(k), 32'h50 + 32'(k));
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 0, 0, 0);
            chkRf($sformatf("wrap.drain%0d", k), 1, 5'd10 + 5'(k), 32'h50 + 32'(k), 0);
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("wrap.count", 64'(md_count), 0);

        // simultaneous push and pop
        drive(0, 0, 0, 1, 5'd2, 32'h62);
        drive(0, 0, 0, 1, 5'd3, 32'h63);
        chkRf("pp.pop", 1, 2, 32'h62, 0);
        chk("pp.count1", 64'(md_count), 1);
        drive(0, 0, 0, 0, 0, 0);
        chkRf("pp.next", 1, 3, 32'h63, 0);
        chk("pp.count1b", 64'(md_count), 1);

        // 5 $0 handling
        drive(1, 5'd0, 32'hDEAD, 1, 5'd9, 32'h55);
        chkRf("z.empty", 0, 0, 0, 0);
        drive(1, 5'd0, 32'hDEAD, 0, 0, 0);
        chkRf("z.head", 1, 9, 32'h55, 0);
        drive(0, 0, 0, 1, 5'd0, 32'h66);
        chkRf("z.push0", 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chkRf("z.nowrite", 0, 0, 0, 0);
        chk("z.count1", 64'(md_count), 1);
        drive(0, 0, 0, 0, 0, 0);
        chk("z.count0", 64'(md_count), 0);

        // 6 reset mid-drain
        for (int k = 1; k <= 3; k++) drive(1, 5'd20, 32'h202, 1, 5'(k), 32'h70 + 32'(k));
        drive(0, 0, 0, 0, 0, 0);
        chk("r.queued", 64'(md_count), 3);
        chkRf("r.drain", 1, 1, 32'h71, 0);
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        chkRf("r.held", 0, 0, 0, 0);
        chk("r.held.count", 64'(md_count), 0);
        chk("r.held.ready", 64'(md_ready), 0);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        chkRf("r.after1", 0, 0, 0, 0);
        chk("r.after.count", 64'(md_count), 0);
        chk("r.after.ready", 64'(md_ready), 1);
        drive(0, 0, 0, 0, 0, 0);
        chkRf("r.after2", 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
